// File: rtl/decode_queue.sv
// decode_queue: RV32 instruction decoder feeding a DEPTH-entry bundle FIFO.
//
// Fetch hands instructions in over i_valid/o_ready. Each accepted word is
// decoded and stored as a control bundle. Execute takes the head bundle over
// o_valid/i_ready. i_flush empties the queue and drops any instruction
// presented in the same cycle.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid/i_instr/i_pc  fetch side: instruction word and its address
//   o_ready               queue has a free slot (from registered state only)
//   i_flush               discard queued and incoming instructions
//   o_valid/i_ready       execute side handshake for the head bundle
//   o_pc ... o_illegal    head bundle fields, read straight from storage
//
// Optional feature macro: RV_MEXT_EN enables decoding of the M extension
// (OP with funct7 0000001). When the macro is undefined, those encodings
// are flagged illegal.

package rv_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_EQ,
        ALU_NE,
        ALU_LT,
        ALU_GE,
        ALU_LTU,
        ALU_GEU
`ifdef RV_MEXT_EN
        ,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHSU,
        ALU_MULHU,
        ALU_DIV,
        ALU_DIVU,
        ALU_REM,
        ALU_REMU
`endif
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC4 = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic    reg_we;
        wb_src_e wb_src;
    } wb_ctrl_reg_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [2:0] mem_funct3;   // access size and sign for the LSU
    } mem_ctrl_reg_t;

    typedef struct packed {
        logic op_a_pc;    // operand A = PC instead of rs1
        logic op_b_imm;   // operand B = immediate instead of rs2
    } alu_op_mux_t;

    typedef enum logic {
        ALU_OUT_RESULT = 1'b0,
        ALU_OUT_IMM    = 1'b1   // LUI passes the immediate through
    } alu_out_mux_t;

    typedef enum logic {
        BR_TGT_PC_IMM  = 1'b0,
        BR_TGT_RS1_IMM = 1'b1
    } branch_target_mux_t;

    typedef struct packed {
        wb_ctrl_reg_t       wb_ctrl;
        mem_ctrl_reg_t      mem_ctrl;
        alu_ctrl_e          alu_ctrl;
        alu_op_mux_t        alu_op_mux;
        alu_out_mux_t       alu_out_mux;
        branch_target_mux_t branch_target_mux;
        logic               do_branch;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [31:0]        imm;
        logic               illegal;
    } dec_bundle_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

module decode_queue
    import rv_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PC_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic [31:0]        i_instr,
    input  logic [PC_W-1:0]    i_pc,
    output logic               o_ready,
    input  logic               i_flush,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [PC_W-1:0]    o_pc,
    output wb_ctrl_reg_t       o_wb_ctrl,
    output mem_ctrl_reg_t      o_mem_ctrl,
    output alu_ctrl_e          o_alu_ctrl,
    output alu_op_mux_t        o_alu_op_mux,
    output alu_out_mux_t       o_alu_out_mux,
    output branch_target_mux_t o_branch_target_mux,
    output logic               o_do_branch,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_rs1,
    output logic [4:0]         o_rs2,
    output logic [31:0]        o_imm,
    output logic               o_illegal
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    dec_bundle_t dec;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'h000};
    assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                    i_instr[20], i_instr[30:21], 1'b0};

    // Field decode; side-effecting controls are squashed for illegal words
    always_comb begin
        dec                     = '0;
        dec.alu_ctrl            = ALU_ADD;
        dec.wb_ctrl.wb_src      = WB_SRC_ALU;
        dec.alu_out_mux         = ALU_OUT_RESULT;
        dec.branch_target_mux   = BR_TGT_PC_IMM;
        dec.rd                  = i_instr[11:7];
        dec.rs1                 = i_instr[19:15];
        dec.rs2                 = i_instr[24:20];
        dec.mem_ctrl.mem_funct3 = funct3;

        case (opcode)
            OPC_LUI: begin
                dec.wb_ctrl.reg_we = 1'b1;
                dec.alu_out_mux    = ALU_OUT_IMM;
                dec.imm            = imm_u;
            end
            OPC_AUIPC: begin
                dec.wb_ctrl.reg_we      = 1'b1;
                dec.alu_op_mux.op_a_pc  = 1'b1;
                dec.alu_op_mux.op_b_imm = 1'b1;
                dec.imm                 = imm_u;
            end
            OPC_JAL: begin
                dec.wb_ctrl.reg_we = 1'b1;
                dec.wb_ctrl.wb_src = WB_SRC_PC4;
                dec.do_branch      = 1'b1;
                dec.imm            = imm_j;
            end
            OPC_JALR: begin
                dec.wb_ctrl.reg_we    = 1'b1;
                dec.wb_ctrl.wb_src    = WB_SRC_PC4;
                dec.do_branch         = 1'b1;
                dec.branch_target_mux = BR_TGT_RS1_IMM;
                dec.imm               = imm_i;
                dec.illegal           = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.do_branch = 1'b1;
                dec.imm       = imm_b;
                case (funct3)
                    3'b000:  dec.alu_ctrl = ALU_EQ;
                    3'b001:  dec.alu_ctrl = ALU_NE;
                    3'b100:  dec.alu_ctrl = ALU_LT;
                    3'b101:  dec.alu_ctrl = ALU_GE;
                    3'b110:  dec.alu_ctrl = ALU_LTU;
                    3'b111:  dec.alu_ctrl = ALU_GEU;
                    default: dec.illegal  = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec.wb_ctrl.reg_we      = 1'b1;
                dec.wb_ctrl.wb_src      = WB_SRC_MEM;
                dec.mem_ctrl.mem_read   = 1'b1;
                dec.alu_op_mux.op_b_imm = 1'b1;
                dec.imm                 = imm_i;
                dec.illegal             = (funct3 == 3'b011) ||
                                          (funct3 == 3'b110) ||
                                          (funct3 == 3'b111);
            end
            OPC_STORE: begin
                dec.mem_ctrl.mem_write  = 1'b1;
                dec.alu_op_mux.op_b_imm = 1'b1;
                dec.imm                 = imm_s;
                dec.illegal             = (funct3 > 3'b010);
            end
            OPC_OP_IMM: begin
                dec.wb_ctrl.reg_we      = 1'b1;
                dec.alu_op_mux.op_b_imm = 1'b1;
                dec.imm                 = imm_i;
                case (funct3)
                    3'b000: dec.alu_ctrl = ALU_ADD;
                    3'b010: dec.alu_ctrl = ALU_SLT;
                    3'b011: dec.alu_ctrl = ALU_SLTU;
                    3'b100: dec.alu_ctrl = ALU_XOR;
                    3'b110: dec.alu_ctrl = ALU_OR;
                    3'b111: dec.alu_ctrl = ALU_AND;
                    3'b001: begin
                        dec.alu_ctrl = ALU_SLL;
                        dec.illegal  = (funct7 != 7'b0000000);
                    end
                    default: begin
                        if (funct7 == 7'b0000000) begin
                            dec.alu_ctrl = ALU_SRL;
                        end else if (funct7 == 7'b0100000) begin
                            dec.alu_ctrl = ALU_SRA;
                        end else begin
                            dec.illegal = 1'b1;
                        end
                    end
                endcase
            end
            OPC_OP: begin
                dec.wb_ctrl.reg_we = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_ADD;
                        3'b001:  dec.alu_ctrl = ALU_SLL;
                        3'b010:  dec.alu_ctrl = ALU_SLT;
                        3'b011:  dec.alu_ctrl = ALU_SLTU;
                        3'b100:  dec.alu_ctrl = ALU_XOR;
                        3'b101:  dec.alu_ctrl = ALU_SRL;
                        3'b110:  dec.alu_ctrl = ALU_OR;
                        default: dec.alu_ctrl = ALU_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_SUB;
                        3'b101:  dec.alu_ctrl = ALU_SRA;
                        default: dec.illegal  = 1'b1;
                    endcase
                end else if (funct7 == 7'b0000001) begin
`ifdef RV_MEXT_EN
                    case (funct3)
                        3'b000:  dec.alu_ctrl = ALU_MUL;
                        3'b001:  dec.alu_ctrl = ALU_MULH;
                        3'b010:  dec.alu_ctrl = ALU_MULHSU;
                        3'b011:  dec.alu_ctrl = ALU_MULHU;
                        3'b100:  dec.alu_ctrl = ALU_DIV;
                        3'b101:  dec.alu_ctrl = ALU_DIVU;
                        3'b110:  dec.alu_ctrl = ALU_REM;
                        default: dec.alu_ctrl = ALU_REMU;
                    endcase
`else
                    dec.illegal = 1'b1;
`endif
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: dec.illegal = 1'b1;
        endcase

        if (dec.illegal) begin
            dec.wb_ctrl.reg_we     = 1'b0;
            dec.mem_ctrl.mem_read  = 1'b0;
            dec.mem_ctrl.mem_write = 1'b0;
            dec.do_branch          = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Bundle FIFO
    // ------------------------------------------------------------------
    dec_bundle_t     bundle_mem [DEPTH];
    logic [PC_W-1:0] pc_mem     [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    assign push = i_valid && ready_q && !i_flush;
    assign pop  = valid_q && i_ready && !i_flush;

    // Next pointer/count state; flush wins over push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
        valid_d = (cnt_d != '0);
        ready_d = (cnt_d < CNT_W'(DEPTH));
    end

    // State and storage registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                bundle_mem[i] <= '0;
                pc_mem[i]     <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
            if (push) begin
                bundle_mem[wr_ptr_q] <= dec;
                pc_mem[wr_ptr_q]     <= i_pc;
            end
        end
    end

    // Head fields straight from storage
    assign o_ready             = ready_q;
    assign o_valid             = valid_q;
    assign o_pc                = pc_mem[rd_ptr_q];
    assign o_wb_ctrl           = bundle_mem[rd_ptr_q].wb_ctrl;
    assign o_mem_ctrl          = bundle_mem[rd_ptr_q].mem_ctrl;
    assign o_alu_ctrl          = bundle_mem[rd_ptr_q].alu_ctrl;
    assign o_alu_op_mux        = bundle_mem[rd_ptr_q].alu_op_mux;
    assign o_alu_out_mux       = bundle_mem[rd_ptr_q].alu_out_mux;
    assign o_branch_target_mux = bundle_mem[rd_ptr_q].branch_target_mux;
    assign o_do_branch         = bundle_mem[rd_ptr_q].do_branch;
    assign o_rd                = bundle_mem[rd_ptr_q].rd;
    assign o_rs1               = bundle_mem[rd_ptr_q].rs1;
    assign o_rs2               = bundle_mem[rd_ptr_q].rs2;
    assign o_imm               = bundle_mem[rd_ptr_q].imm;
    assign o_illegal           = bundle_mem[rd_ptr_q].illegal;

endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue with hand-computed expected values.
module tb_decode_queue;
    import rv_pkg::*;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic [31:0]        instr;
    logic [31:0]        pc;
    logic               out_ready_q;
    logic               flush;
    logic               out_valid;
    logic               exe_ready;
    logic [31:0]        head_pc;
    wb_ctrl_reg_t       wb_ctrl;
    mem_ctrl_reg_t      mem_ctrl;
    alu_ctrl_e          alu_ctrl;
    alu_op_mux_t        alu_op_mux;
    alu_out_mux_t       alu_out_mux;
    branch_target_mux_t br_mux;
    logic               do_branch;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        imm;
    logic               illegal;

    int checks = 0;
    int errors = 0;

    decode_queue #(.DEPTH(2), .PC_W(32)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_valid             (in_valid),
        .i_instr             (instr),
        .i_pc                (pc),
        .o_ready             (out_ready_q),
        .i_flush             (flush),
        .o_valid             (out_valid),
        .i_ready             (exe_ready),
        .o_pc                (head_pc),
        .o_wb_ctrl           (wb_ctrl),
        .o_mem_ctrl          (mem_ctrl),
        .o_alu_ctrl          (alu_ctrl),
        .o_alu_op_mux        (alu_op_mux),
        .o_alu_out_mux       (alu_out_mux),
        .o_branch_target_mux (br_mux),
        .o_do_branch         (do_branch),
        .o_rd                (rd),
        .o_rs1               (rs1),
        .o_rs2               (rs2),
        .o_imm               (imm),
        .o_illegal           (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push one instruction into an empty queue with execute stalled
    task automatic push_one(input logic [31:0] w, input logic [31:0] a);
        in_valid  = 1'b1;
        instr     = w;
        pc        = a;
        exe_ready = 1'b0;
        tick();
        in_valid  = 1'b0;
    endtask

    // Consume the head entry
    task automatic pop_one();
        exe_ready = 1'b1;
        tick();
        exe_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        pc        = '0;
        flush     = 1'b0;
        exe_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        check_eq("rst_valid",   64'(out_valid), 64'd0);
        check_eq("rst_ready",   64'(out_ready_q), 64'd1);
        check_eq("rst_pc",      64'(head_pc), 64'd0);
        check_eq("rst_imm",     64'(imm), 64'd0);
        check_eq("rst_illegal", 64'(illegal), 64'd0);
        check_eq("rst_regwe",   64'(wb_ctrl.reg_we), 64'd0);

        // add x3,x1,x2
        push_one(32'h002081B3, 32'h100);
        check_eq("add_valid",   64'(out_valid), 64'd1);
        check_eq("add_alu",     64'(alu_ctrl), 64'(ALU_ADD));
        check_eq("add_regwe",   64'(wb_ctrl.reg_we), 64'd1);
        check_eq("add_rd",      64'(rd), 64'd3);
        check_eq("add_rs1",     64'(rs1), 64'd1);
        check_eq("add_rs2",     64'(rs2), 64'd2);
        check_eq("add_pc",      64'(head_pc), 64'h100);
        check_eq("add_illegal", 64'(illegal), 64'd0);
        check_eq("add_ready",   64'(out_ready_q), 64'd1);
        pop_one();
        check_eq("add_drained", 64'(out_valid), 64'd0);

        // Back-pressure: three addi pushes into DEPTH=2, execute stalled
        exe_ready = 1'b0;
        in_valid  = 1'b1;
        instr = 32'h00100093; pc = 32'h200; tick();
        check_eq("bp1_ready", 64'(out_ready_q), 64'd1);
        instr = 32'h00200113; pc = 32'h204; tick();
        check_eq("bp2_ready", 64'(out_ready_q), 64'd0);
        check_eq("bp2_head",  64'(head_pc), 64'h200);
        instr = 32'h00300193; pc = 32'h208; tick();
        check_eq("bp3_ready", 64'(out_ready_q), 64'd0);
        check_eq("bp3_head",  64'(head_pc), 64'h200);
        check_eq("bp3_imm",   64'(imm), 64'd1);
        exe_ready = 1'b1;
        tick();
        check_eq("drain1_pc",    64'(head_pc), 64'h204);
        check_eq("drain1_imm",   64'(imm), 64'd2);
        check_eq("drain1_ready", 64'(out_ready_q), 64'd1);
        tick();
        in_valid = 1'b0;
        check_eq("drain2_pc",  64'(head_pc), 64'h208);
        check_eq("drain2_rd",  64'(rd), 64'd3);
        check_eq("drain2_imm", 64'(imm), 64'd3);
        tick();
        exe_ready = 1'b0;
        check_eq("drain3_valid", 64'(out_valid), 64'd0);

        // Branches back-to-back with execute consuming
        exe_ready = 1'b1;
        in_valid  = 1'b1;
        instr = 32'h0020F463; pc = 32'h300; tick();
        check_eq("bgeu_alu",    64'(alu_ctrl), 64'(ALU_GEU));
        check_eq("bgeu_br",     64'(do_branch), 64'd1);
        check_eq("bgeu_imm",    64'(imm), 64'd8);
        check_eq("bgeu_regwe",  64'(wb_ctrl.reg_we), 64'd0);
        instr = 32'hFE000EE3; pc = 32'h304; tick();
        in_valid = 1'b0;
        check_eq("beq_pc",  64'(head_pc), 64'h304);
        check_eq("beq_alu", 64'(alu_ctrl), 64'(ALU_EQ));
        check_eq("beq_imm", 64'(imm), 64'hFFFFFFFC);
        tick();
        exe_ready = 1'b0;
        check_eq("br_drained", 64'(out_valid), 64'd0);

        // All-zero word is illegal
        push_one(32'h00000000, 32'h400);
        check_eq("zero_illegal", 64'(illegal), 64'd1);
        check_eq("zero_regwe",   64'(wb_ctrl.reg_we), 64'd0);
        check_eq("zero_memrd",   64'(mem_ctrl.mem_read), 64'd0);
        check_eq("zero_br",      64'(do_branch), 64'd0);
        pop_one();

        // LOAD funct3=011 is illegal, controls squashed
        push_one(32'h0000B083, 32'h404);
        check_eq("ld_illegal", 64'(illegal), 64'd1);
        check_eq("ld_memrd",   64'(mem_ctrl.mem_read), 64'd0);
        check_eq("ld_regwe",   64'(wb_ctrl.reg_we), 64'd0);
        pop_one();

        // lw x1,0(x1)
        push_one(32'h0000A083, 32'h408);
        check_eq("lw_illegal", 64'(illegal), 64'd0);
        check_eq("lw_memrd",   64'(mem_ctrl.mem_read), 64'd1);
        check_eq("lw_regwe",   64'(wb_ctrl.reg_we), 64'd1);
        check_eq("lw_wbsrc",   64'(wb_ctrl.wb_src), 64'(WB_SRC_MEM));
        check_eq("lw_f3",      64'(mem_ctrl.mem_funct3), 64'd2);
        pop_one();

        // sw x2,4(x1)
        push_one(32'h0020A223, 32'h40C);
        check_eq("sw_memwr", 64'(mem_ctrl.mem_write), 64'd1);
        check_eq("sw_imm",   64'(imm), 64'd4);
        check_eq("sw_regwe", 64'(wb_ctrl.reg_we), 64'd0);
        pop_one();

        // srai x1,x1,1
        push_one(32'h4010D093, 32'h410);
        check_eq("srai_alu",  64'(alu_ctrl), 64'(ALU_SRA));
        check_eq("srai_opb",  64'(alu_op_mux.op_b_imm), 64'd1);
        check_eq("srai_ill",  64'(illegal), 64'd0);
        pop_one();

        // lui x1,0x12345
        push_one(32'h123450B7, 32'h414);
        check_eq("lui_imm",  64'(imm), 64'h12345000);
        check_eq("lui_out",  64'(alu_out_mux), 64'(ALU_OUT_IMM));
        check_eq("lui_opa",  64'(alu_op_mux.op_a_pc), 64'd0);
        pop_one();

        // jalr x0,0(x1)
        push_one(32'h00008067, 32'h418);
        check_eq("jalr_tgt",   64'(br_mux), 64'(BR_TGT_RS1_IMM));
        check_eq("jalr_br",    64'(do_branch), 64'd1);
        check_eq("jalr_wbsrc", 64'(wb_ctrl.wb_src), 64'(WB_SRC_PC4));
        pop_one();

        // Flush with a full queue and a new instruction presented
        exe_ready = 1'b0;
        in_valid  = 1'b1;
        instr = 32'h00100093; pc = 32'h500; tick();
        instr = 32'h00200113; pc = 32'h504; tick();
        instr = 32'h00300193; pc = 32'h508; flush = 1'b1; tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("flush_valid", 64'(out_valid), 64'd0);
        check_eq("flush_ready", 64'(out_ready_q), 64'd1);
        exe_ready = 1'b1;
        tick();
        check_eq("flush_gone", 64'(out_valid), 64'd0);
        exe_ready = 1'b0;

        // Flush with room: presented instruction is dropped, queue restarts
        in_valid = 1'b1; instr = 32'h00500293; pc = 32'h600; flush = 1'b1; tick();
        flush = 1'b0;
        check_eq("flush2_valid", 64'(out_valid), 64'd0);
        instr = 32'h00600313; pc = 32'h604; tick();
        in_valid = 1'b0;
        check_eq("post_flush_valid", 64'(out_valid), 64'd1);
        check_eq("post_flush_pc",    64'(head_pc), 64'h604);
        check_eq("post_flush_imm",   64'(imm), 64'd6);
        pop_one();

        // mul x5,x6,x7
        push_one(32'h027302B3, 32'h700);
`ifdef RV_MEXT_EN
        check_eq("mul_alu",   64'(alu_ctrl), 64'(ALU_MUL));
        check_eq("mul_regwe", 64'(wb_ctrl.reg_we), 64'd1);
        check_eq("mul_ill",   64'(illegal), 64'd0);
`else
        check_eq("mul_ill",   64'(illegal), 64'd1);
        check_eq("mul_regwe", 64'(wb_ctrl.reg_we), 64'd0);
`endif
        pop_one();

        // Reset mid-operation clears storage
        push_one(32'h00100093, 32'h800);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst2_valid", 64'(out_valid), 64'd0);
        check_eq("rst2_ready", 64'(out_ready_q), 64'd1);
        check_eq("rst2_pc",    64'(head_pc), 64'd0);
        check_eq("rst2_imm",   64'(imm), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Registered, parametrised successor to the combinational control decoder. It accepts fetched RV32 instructions over a valid/ready handshake and decodes each into the standard `rv_pkg` control bundle. The bundle is extended with register indices, a generated immediate, the PC and an illegal-instruction flag. Bundles are held in a DEPTH-entry FIFO between fetch and execute, giving the pipeline decode buffering, back-pressure and flush.

## Interface
- `DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `PC_W`, default 32: PC width carried with each bundle.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_valid`  in  1  fetch presents an instruction.
- `i_instr`  in  32  instruction word.
- `i_pc`  in  PC_W  instruction address.
- `o_ready`  out  1  queue can accept this cycle.
- `i_flush`  in  1  discard all queued and incoming instructions.
- `o_valid`  out  1  head bundle valid.
- `i_ready`  in  1  execute consumes head.
- `o_pc`  out  PC_W  head PC.
- `o_wb_ctrl`  out  wb_ctrl_reg_t.
- `o_mem_ctrl`  out  mem_ctrl_reg_t.
- `o_alu_ctrl`  out  alu_ctrl_e.
- `o_alu_op_mux`  out  alu_op_mux_t.
- `o_alu_out_mux`  out  alu_out_mux_t.
- `o_branch_target_mux`  out  branch_target_mux_t.
- `o_do_branch`  out  1.
- `o_rd`, `o_rs1`, `o_rs2`  out  5 each  instr[11:7], [19:15], [24:20].
- `o_imm`  out  32  sign-extended immediate.
- `o_illegal`  out  1  head instruction is not a supported encoding.

## Operation
- Decode is combinational on `i_instr`. It covers the LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM and OP opcodes. Defaults and field values match the existing control unit, with these additions:
  - OP-IMM funct3 001 → ALU_SLL; 101 with funct7 0000000 → ALU_SRL; 101 with funct7 0100000 → ALU_SRA.
  - BRANCH funct3 111 → ALU_GEU.
- Immediate by format, all sign-extended from bit 31:
  - I-format: LOAD, OP-IMM, JALR.
  - S-format: STORE.
  - B-format: BRANCH.
  - U-format: LUI, AUIPC.
  - J-format: JAL.
  - R-format: 0.
- `o_illegal`=1 for any of:
  - an unlisted opcode;
  - an OP funct7/funct3 pair outside the table;
  - an OP-IMM shift with a bad funct7;
  - LOAD funct3 ∈ {011, 110, 111};
  - STORE funct3 > 010;
  - BRANCH funct3 ∈ {010, 011};
  - JALR funct3 ≠ 000.
- An illegal bundle forces `reg_we`, `mem_read`, `mem_write` and `o_do_branch` to 0.
- FIFO behaviour:
  - Write pointer, read pointer and count cover 0..DEPTH.
  - Push when `i_valid && o_ready && !i_flush`. Pop when `o_valid && i_ready`.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Pointers wrap modulo DEPTH.
- `o_ready` = (count < DEPTH), driven from registered state only. There is no input-to-output combinational path and no full-bypass.

## Timing
- Latency: an instruction accepted in cycle N appears at the head in cycle N+1 if the queue was empty. Throughput is 1 instruction/cycle.
- Order is strictly FIFO. Head outputs come directly from registered storage.
- Head outputs are stable while `o_valid && !i_ready`.
- Full (count = DEPTH): `o_ready`=0 and input is held by fetch. A pop in that cycle frees the slot, and `o_ready` rises in the next cycle.
- Empty: `o_valid`=0, and `i_ready` is ignored.
- `i_flush`:
  - Takes priority over push and pop.
  - Next cycle: count=0, pointers=0, `o_valid`=0, `o_ready`=1.
  - An instruction presented in the flush cycle is dropped.
- Reset:
  - Count and pointers are set to 0, and all storage is cleared to zero.
  - `o_valid`=0 and `o_ready`=1.
  - Every head field reads 0: `o_pc`, `o_imm`, register indices, `o_illegal`, `o_do_branch`, and all ctrl struct bits (enums at value 0).
  - Reset mid-operation discards all entries the same way.

## Configuration
- `RV_MEXT_EN` defined: OP with funct7 0000001 decodes funct3 000..111 to ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU, with `reg_we`=1. These enum members exist in `rv_pkg` under the same macro.
- `RV_MEXT_EN` undefined: funct7 0000001 encodings are illegal (`o_illegal`=1, `reg_we`=0).

## Test plan
- Reset, then push 0x002081B3 (add x3,x1,x2, pc 0x100) → next cycle `o_valid`=1, ALU_ADD, `reg_we`=1, rd=3, rs1=1, rs2=2, `o_pc`=0x100, `o_illegal`=0.
- DEPTH=2, `i_ready`=0, push three instructions back-to-back → `o_ready` falls after two; the third is held. Raising `i_ready` drains them in order, one per cycle.
- Push 0x0020F463 (bgeu x1,x2,+8) → ALU_GEU, `o_do_branch`=1, `o_imm`=8. Push 0xFE000EE3 (beq x0,x0,−4) → `o_imm`=0xFFFFFFFC.
- Push 0x00000000 → `o_illegal`=1, `reg_we`=0, `mem_read`=0, `o_do_branch`=0.
- Fill two entries, assert `i_flush` with `i_valid`=1 → next cycle `o_valid`=0, `o_ready`=1, and the flushed-cycle instruction never appears.
- Push 0x027302B3 (mul x5,x6,x7) → with `RV_MEXT_EN`: ALU_MUL, `reg_we`=1. Without it: `o_illegal`=1.
